// File: rtl/axis_debugger_pkg.sv
// Shared definitions for the axis_debugger slice: frame-gate state encoding.
package axis_debugger_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_STOPPING = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_ARMED    = ST_ARMED,
    S_RUN      = ST_RUN,
    S_STOPPING = ST_STOPPING,
    S_DONE     = ST_DONE
  } gate_state_e;

endpackage

// File: rtl/axis_frame_gate.sv
// Frame-aligned AXI-Stream gate: passes whole frames between arm and abort/limit.
// Optional macro AXIS_FRAME_GATE_DROP_COUNT_EN adds the dropped_beats counter output.
module axis_frame_gate
  import axis_debugger_pkg::*;
#(
  parameter int C_AXIS_BYTEWIDTH = 4,
  parameter int C_COUNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          input_s_axis_tvalid,
  input  logic [8*C_AXIS_BYTEWIDTH-1:0] input_s_axis_tdata,
  input  logic [C_AXIS_BYTEWIDTH-1:0]   input_s_axis_tstrb,
  input  logic                          input_s_axis_tlast,
  output logic                          input_s_axis_tready,
  output logic                          output_m_axis_tvalid,
  output logic [8*C_AXIS_BYTEWIDTH-1:0] output_m_axis_tdata,
  output logic [C_AXIS_BYTEWIDTH-1:0]   output_m_axis_tstrb,
  output logic                          output_m_axis_tlast,
  input  logic                          output_m_axis_tready,
  input  logic                          arm,
  input  logic                          abort,
  input  logic [C_COUNT_WIDTH-1:0]      frame_limit,
  output logic [2:0]                    state,
  output logic [C_COUNT_WIDTH-1:0]      frames_passed,
  output logic                          done
`ifdef AXIS_FRAME_GATE_DROP_COUNT_EN
  ,
  output logic [C_COUNT_WIDTH-1:0]      dropped_beats
`endif
);

  localparam logic [C_COUNT_WIDTH-1:0] ONE_C = {{(C_COUNT_WIDTH-1){1'b0}}, 1'b1};

  gate_state_e              state_r, state_nxt_s;
  logic                     in_frame_r;
  logic                     done_r;
  logic [C_COUNT_WIDTH-1:0] limit_r;
  logic [C_COUNT_WIDTH-1:0] frames_r, frames_nxt_s, frames_inc_s;
  logic                     pass_s, accept_s, last_acc_s, arm_ok_s;

  assign pass_s       = (state_r == S_RUN) || (state_r == S_STOPPING);
  assign accept_s     = input_s_axis_tvalid && input_s_axis_tready;
  assign last_acc_s   = accept_s && input_s_axis_tlast;
  assign frames_inc_s = frames_r + ONE_C;

  // Zero-latency pass-through while open; otherwise sink and discard every beat.
  always_comb begin
    input_s_axis_tready  = 1'b1;
    output_m_axis_tvalid = 1'b0;
    output_m_axis_tdata  = '0;
    output_m_axis_tstrb  = '0;
    output_m_axis_tlast  = 1'b0;
    if (pass_s) begin
      input_s_axis_tready  = output_m_axis_tready;
      output_m_axis_tvalid = input_s_axis_tvalid;
      output_m_axis_tdata  = input_s_axis_tdata;
      output_m_axis_tstrb  = input_s_axis_tstrb;
      output_m_axis_tlast  = input_s_axis_tlast;
    end else begin
      input_s_axis_tready  = 1'b1;
    end
  end

  // Next-state and frame counter; abort always takes priority over arm.
  always_comb begin
    state_nxt_s  = state_r;
    frames_nxt_s = frames_r;
    arm_ok_s     = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (arm && !abort) begin
          arm_ok_s     = 1'b1;
          frames_nxt_s = '0;
          state_nxt_s  = (!in_frame_r && !accept_s) ? S_RUN : S_ARMED;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_ARMED: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (last_acc_s) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_ARMED;
        end
      end
      S_RUN: begin
        if (last_acc_s) begin
          frames_nxt_s = frames_inc_s;
        end else begin
          frames_nxt_s = frames_r;
        end
        if (abort) begin
          state_nxt_s = (!in_frame_r && !accept_s) ? S_IDLE : S_STOPPING;
        end else if (last_acc_s && (limit_r != '0) && (frames_inc_s == limit_r)) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_STOPPING: begin
        if (last_acc_s) begin
          frames_nxt_s = frames_inc_s;
          state_nxt_s  = S_IDLE;
        end else begin
          state_nxt_s  = S_STOPPING;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, frame tracking and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      in_frame_r <= 1'b0;
      frames_r   <= '0;
      limit_r    <= '0;
      done_r     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      frames_r <= frames_nxt_s;
      done_r   <= (state_nxt_s == S_DONE);
      if (accept_s) begin
        in_frame_r <= !input_s_axis_tlast;
      end else begin
        in_frame_r <= in_frame_r;
      end
      if (arm_ok_s) begin
        limit_r <= frame_limit;
      end else begin
        limit_r <= limit_r;
      end
    end
  end

  assign state         = state_r;
  assign frames_passed = frames_r;
  assign done          = done_r;

`ifdef AXIS_FRAME_GATE_DROP_COUNT_EN
  logic [C_COUNT_WIDTH-1:0] drop_r;

  // Saturating count of beats swallowed while the gate is closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_r <= '0;
    end else if (arm_ok_s) begin
      drop_r <= '0;
    end else if (accept_s && !pass_s && (drop_r != '1)) begin
      drop_r <= drop_r + ONE_C;
    end else begin
      drop_r <= drop_r;
    end
  end

  assign dropped_beats = drop_r;
`endif

endmodule
